// File: rtl/operand_fetch.sv
// Operand fetch stage: register file read into a 2-entry FIFO that feeds the shifter.
// Optional write-to-read bypass enabled by defining OPERAND_FETCH_BYPASS_EN.
module operand_fetch #(
   parameter  int DATA_W = 16,
   parameter  int NREGS  = 8,
   localparam int AW     = $clog2(NREGS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_valid,
   output logic              rd_ready,
   input  logic [AW-1:0]     rd_addr,
   input  logic [1:0]        rd_shift,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        out_shift
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [DATA_W-1:0] r_regs      [NREGS];
   logic [DATA_W-1:0] r_fifo_data [2];
   logic [1:0]        r_fifo_shift[2];
   logic              r_wptr;
   logic              r_rptr;
   logic              w_rd_ready;
   logic              w_out_valid;
   logic              w_accept;
   logic              w_pop;
   logic [DATA_W-1:0] w_operand;

   assign w_accept  = rd_valid && w_rd_ready;
   assign w_pop     = w_out_valid && out_ready;
   assign rd_ready  = w_rd_ready;
   assign out_valid = w_out_valid;
   // Head entry comes straight from FIFO flops, so no input reaches the outputs combinationally.
   assign out_data  = r_fifo_data[r_rptr];
   assign out_shift = r_fifo_shift[r_rptr];

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next-state: occupancy moves by accept minus pop
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_EMPTY: begin
            if (w_accept) w_state_nxt = ST_ONE;
            else          w_state_nxt = ST_EMPTY;
         end
         ST_ONE: begin
            if (w_accept && !w_pop)      w_state_nxt = ST_TWO;
            else if (!w_accept && w_pop) w_state_nxt = ST_EMPTY;
            else                         w_state_nxt = ST_ONE;
         end
         ST_TWO: begin
            if (w_pop) w_state_nxt = ST_ONE;
            else       w_state_nxt = ST_TWO;
         end
         default: w_state_nxt = ST_EMPTY;
      endcase
   end

   // FSM outputs, decoded from state alone
   always_comb begin
      w_rd_ready  = 1'b1;
      w_out_valid = 1'b0;
      case (r_state)
         ST_EMPTY: begin w_rd_ready = 1'b1; w_out_valid = 1'b0; end
         ST_ONE:   begin w_rd_ready = 1'b1; w_out_valid = 1'b1; end
         ST_TWO:   begin w_rd_ready = 1'b0; w_out_valid = 1'b1; end
         default:  begin w_rd_ready = 1'b1; w_out_valid = 1'b0; end
      endcase
   end

   // Operand selection for a fetch in this cycle
   always_comb begin
      w_operand = r_regs[rd_addr];
`ifdef OPERAND_FETCH_BYPASS_EN
      if (wr_en && (wr_addr == rd_addr)) begin
         w_operand = wr_data;
      end else begin
         w_operand = r_regs[rd_addr];
      end
`endif
   end

   // Register file write port
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) begin
            r_regs[i] <= {DATA_W{1'b0}};
         end
      end else if (wr_en) begin
         r_regs[wr_addr] <= wr_data;
      end
   end

   // FIFO storage and pointers; 1-bit pointers wrap naturally
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fifo_data[0]  <= {DATA_W{1'b0}};
         r_fifo_data[1]  <= {DATA_W{1'b0}};
         r_fifo_shift[0] <= 2'b00;
         r_fifo_shift[1] <= 2'b00;
         r_wptr          <= 1'b0;
         r_rptr          <= 1'b0;
      end else begin
         if (w_accept) begin
            r_fifo_data[r_wptr]  <= w_operand;
            r_fifo_shift[r_wptr] <= rd_shift;
            r_wptr               <= r_wptr + 1'b1;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboard bench for operand_fetch: reference model predicts operands, monitor checks outputs.
module tb_operand_fetch;
   localparam int DW = 16;
   localparam int NR = 8;
   localparam int AW = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          wr_en = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [DW-1:0] wr_data = '0;
   logic          rd_valid = 1'b0;
   logic          rd_ready;
   logic [AW-1:0] rd_addr = '0;
   logic [1:0]    rd_shift = 2'b00;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [DW-1:0] out_data;
   logic [1:0]    out_shift;

   typedef struct packed {
      logic [DW-1:0] data;
      logic [1:0]    shift;
   } exp_t;

   exp_t          exp_q[$];
   logic [DW-1:0] model_regs[NR];
   int            model_cnt = 0;
   int            n_tests = 0;
   int            n_fail = 0;

   operand_fetch #(.DATA_W(DW), .NREGS(NR)) dut (
      .clk(clk), .rst_n(rst_n),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr), .rd_shift(rd_shift),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_shift(out_shift)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_model();
      exp_q.delete();
      model_cnt = 0;
      for (int i = 0; i < NR; i++) model_regs[i] = '0;
   endtask

   // Predictor: occupancy model plus expected operand for each accepted fetch
   always @(negedge clk) begin : predictor
      exp_t e;
      logic acc;
      logic pop;
      if (rst_n) begin
         check("rd_ready", 32'(rd_ready), 32'(model_cnt < 2));
         check("out_valid", 32'(out_valid), 32'(model_cnt > 0));
         acc = rd_valid && (model_cnt < 2);
         pop = out_ready && (model_cnt > 0);
         if (acc) begin
            e.data = model_regs[rd_addr];
`ifdef OPERAND_FETCH_BYPASS_EN
            if (wr_en && (wr_addr == rd_addr)) e.data = wr_data;
`endif
            e.shift = rd_shift;
            exp_q.push_back(e);
         end
         model_cnt = model_cnt + (acc ? 1 : 0) - (pop ? 1 : 0);
         if (wr_en) model_regs[wr_addr] = wr_data;
      end
   end

   // Monitor: the presented head must equal the oldest outstanding prediction
   always @(negedge clk) begin : monitor
      if (rst_n && out_valid) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_empty: out_valid=1 with data 0x%0h but nothing expected", out_data);
         end else begin
            check("out_data", 32'(out_data), 32'(exp_q[0].data));
            check("out_shift", 32'(out_shift), 32'(exp_q[0].shift));
            if (out_ready) void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      clear_model();
      #2;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_rd_ready", 32'(rd_ready), 32'd1);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_out_shift", 32'(out_shift), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // basic write then fetch with one-cycle latency
      out_ready = 1'b1;
      wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'h8001;
      step();
      wr_en = 1'b0;
      rd_valid = 1'b1; rd_addr = 3'd3; rd_shift = 2'b11;
      step();
      rd_valid = 1'b0;
      check("lat_valid", 32'(out_valid), 32'd1);
      check("lat_data", 32'(out_data), 32'h8001);
      check("lat_shift", 32'(out_shift), 32'd3);
      step();

      // fill to two entries, third request must be held off
      out_ready = 1'b0;
      wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'h0001;
      step();
      wr_addr = 3'd2; wr_data = 16'h0002;
      step();
      wr_en = 1'b0;
      rd_valid = 1'b1; rd_addr = 3'd1; rd_shift = 2'b01;
      step();
      rd_addr = 3'd2; rd_shift = 2'b10;
      step();
      check("full_rd_ready", 32'(rd_ready), 32'd0);
      rd_addr = 3'd3; rd_shift = 2'b00;
      step();
      step();
      check("full_hold_data", 32'(out_data), 32'h0001);
      rd_valid = 1'b0;
      out_ready = 1'b1;
      step();
      check("full_second", 32'(out_data), 32'h0002);
      step();
      check("full_drained", 32'(out_valid), 32'd0);

      // steady accept+pop in state ONE
      rd_valid = 1'b1; rd_addr = 3'd1; rd_shift = 2'b00;
      step();
      for (int i = 0; i < 10; i++) begin
         rd_addr = AW'(i % NR);
         rd_shift = 2'(i % 4);
         step();
         check("one_valid", 32'(out_valid), 32'd1);
         check("one_ready", 32'(rd_ready), 32'd1);
      end
      rd_valid = 1'b0;
      step();
      step();

      // reset in state TWO, between clock edges
      out_ready = 1'b0;
      rd_valid = 1'b1; rd_addr = 3'd3;
      step();
      step();
      rd_valid = 1'b0;
      check("pre_rst_ready", 32'(rd_ready), 32'd0);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      check("mid_rst_ready", 32'(rd_ready), 32'd1);
      check("mid_rst_data", 32'(out_data), 32'd0);
      check("mid_rst_shift", 32'(out_shift), 32'd0);
      clear_model();
      step();
      rst_n = 1'b1;
      out_ready = 1'b1;
      rd_valid = 1'b1; rd_addr = 3'd5; rd_shift = 2'b10;
      step();
      rd_valid = 1'b0;
      check("post_rst_valid", 32'(out_valid), 32'd1);
      check("post_rst_data", 32'(out_data), 32'd0);
      step();

      // write and fetch of the same register in one cycle
      wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'h1234;
      rd_valid = 1'b1; rd_addr = 3'd5; rd_shift = 2'b01;
      step();
      wr_en = 1'b0; rd_valid = 1'b0;
`ifdef OPERAND_FETCH_BYPASS_EN
      check("same_addr", 32'(out_data), 32'h1234);
`else
      check("same_addr", 32'(out_data), 32'h0000);
`endif
      step();

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         wr_en     = ($urandom_range(0, 1) != 0);
         wr_addr   = AW'($urandom_range(0, NR - 1));
         wr_data   = DW'($urandom);
         rd_valid  = ($urandom_range(0, 3) != 0);
         rd_addr   = AW'($urandom_range(0, NR - 1));
         rd_shift  = 2'($urandom_range(0, 3));
         out_ready = ($urandom_range(0, 2) != 0);
         step();
      end

      // bounded drain
      wr_en = 1'b0; rd_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (exp_q.size() != 0) step();
      end
      step();
      check("drain_left", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 SHALL have parameter DATA_W, default 16, data width of register file and operand output.
REQ-002 SHALL have parameter NREGS, default 8, register count, power of two; AW = log2(NREGS).
REQ-003 SHALL have port clk  input  1  single clock, all state updated on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port wr_en  input  1  register write strobe.
REQ-006 SHALL have port wr_addr  input  AW  write register index.
REQ-007 SHALL have port wr_data  input  DATA_W  write data.
REQ-008 SHALL have port rd_valid  input  1  fetch request valid.
REQ-009 SHALL have port rd_ready  output  1  fetch request accepted when high with rd_valid.
REQ-010 SHALL have port rd_addr  input  AW  register to fetch.
REQ-011 SHALL have port rd_shift  input  2  shift code travelling with operand (00 pass, 01 left, 10 logical right, 11 arithmetic right).
REQ-012 SHALL have port out_valid  output  1  operand available to the shifter.
REQ-013 SHALL have port out_ready  input  1  shifter consumes operand when high with out_valid.
REQ-014 SHALL have port out_data  output  DATA_W  operand fed to the shifter input.
REQ-015 SHALL have port out_shift  output  2  shift code fed to the shifter control.

Function
REQ-016 SHALL hold NREGS x DATA_W registers; write on clk when wr_en, one write per cycle.
REQ-017 SHALL accept a fetch when rd_valid && rd_ready; operand = regfile[rd_addr] captured with rd_shift into a 2-entry FIFO.
REQ-018 SHALL implement FIFO control as FSM EMPTY/ONE/TWO; accept-only: +1, pop-only: -1, accept and pop together: state unchanged.
REQ-019 SHALL drive rd_ready = (state != TWO), combinational from state only, never from out_ready.
REQ-020 SHALL drive out_valid = (state != EMPTY); out_data/out_shift = oldest entry, registered, no combinational path from inputs.
REQ-021 SHALL give latency of one cycle: fetch accepted at edge N, out_valid high after edge N when FIFO was EMPTY.
REQ-022 SHALL hold out_data/out_shift stable while out_valid && !out_ready.
REQ-023 SHALL on simultaneous accept and pop in state ONE present the new entry after the edge (state stays ONE).
REQ-024 SHALL in state TWO ignore rd_valid; no entry overwritten, no request lost.
REQ-025 SHALL ignore out_ready when out_valid is low (no underflow, state stays EMPTY).
REQ-026 SHALL read-before-write when wr_en and accept target same address, unless REQ-032 applies.
REQ-027 SHALL wrap FIFO read/write pointers modulo 2.

Reset
REQ-028 SHALL on rst_n low immediately clear FSM to EMPTY, out_valid to 0, out_data to 0, out_shift to 00, all registers to 0.
REQ-029 SHALL drive rd_ready to 1 during and after reset.
REQ-030 SHALL discard buffered entries on reset mid-operation; first post-reset fetch sees register value 0 unless rewritten.
REQ-031 SHALL resume accepting on first rising clk after rst_n deasserts.

Configuration
REQ-032 SHALL, with macro OPERAND_FETCH_BYPASS_EN defined, forward wr_data to the fetched operand when wr_en && accept && wr_addr == rd_addr in the same cycle.
REQ-033 SHALL, without OPERAND_FETCH_BYPASS_EN, return the pre-write register value in that case (REQ-026); all else identical.

Verification
REQ-034 SHALL cover: reset, write r3=0x8001, fetch r3 shift=11, out_ready=1 -> out_valid one cycle later, out_data=0x8001, out_shift=11.
REQ-035 SHALL cover: out_ready=0, fetch r1=0x0001 then r2=0x0002 -> state TWO, rd_ready=0, third fetch ignored; release out_ready -> 0x0001 then 0x0002 in order.
REQ-036 SHALL cover: state ONE, accept and pop same cycle for 10 cycles -> out_valid stays 1, rd_ready stays 1, data sequence matches issue order.
REQ-037 SHALL cover: write r5=0x1234 while fetching r5, prior r5=0x0000 -> out_data=0x1234 with OPERAND_FETCH_BYPASS_EN, 0x0000 without.
REQ-038 SHALL cover: state TWO, assert rst_n=0 between edges -> out_valid=0, rd_ready=1 immediately; fetch r5 after release -> out_data=0x0000.
